// File: rtl/coh_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coh_cache_ctrl
// Brief    : Direct-mapped coherent cache controller in front of the directory.
//            Optional hit/miss counters are enabled by COH_CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module coh_cache_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int INDEX_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        proc_req,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic              proc_wdata,
    output logic              proc_rdata,
    output logic              proc_ack,
    output logic [1:0]        cache_req,
    output logic [ADDR_W-1:0] blk_add,
    output logic              back_data,
    input  logic              blk_ok,
    input  logic              blk_data,
    input  logic              write_back_req,
    input  logic [ADDR_W-1:0] wb_add,
    input  logic              inval,
    input  logic [ADDR_W-1:0] blocknum
`ifdef COH_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    localparam int c_NUM_LINES = 2**INDEX_W;
    localparam int c_TAG_W     = ADDR_W - INDEX_W;

    localparam logic [1:0] c_LS_INV   = 2'd0;
    localparam logic [1:0] c_LS_SHR   = 2'd1;
    localparam logic [1:0] c_LS_EXC   = 2'd2;
    localparam logic [1:0] c_REQ_IDLE = 2'b00;
    localparam logic [1:0] c_REQ_RD   = 2'b01;
    localparam logic [1:0] c_REQ_EXCL = 2'b10;
    localparam logic [1:0] c_REQ_OK   = 2'b11;
    localparam logic [1:0] c_PREQ_RD  = 2'b01;
    localparam logic [1:0] c_PREQ_WR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_MISS = 3'd1,
        S_WR_MISS = 3'd2,
        S_WB_RESP = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t                              r_state, w_nxt_state;
    state_t                              r_saved_state, w_nxt_saved_state;
    logic [1:0]                          r_cache_req, w_nxt_cache_req;
    logic [1:0]                          r_saved_req, w_nxt_saved_req;
    logic [ADDR_W-1:0]                   r_blk_add, w_nxt_blk_add;
    logic                                r_back_data, w_nxt_back_data;
    logic                                r_proc_rdata, w_nxt_proc_rdata;
    logic [c_NUM_LINES-1:0][1:0]         r_lst, w_nxt_lst;
    logic [c_NUM_LINES-1:0][c_TAG_W-1:0] r_tag, w_nxt_tag;
    logic [c_NUM_LINES-1:0]              r_data, w_nxt_data;
    logic                                w_fill;

    logic [INDEX_W-1:0] w_p_idx, w_wb_idx, w_inv_idx, w_fill_idx;
    logic [c_TAG_W-1:0] w_p_tag, w_wb_tag, w_inv_tag, w_fill_tag;
    logic               w_p_hit, w_p_excl, w_wb_hit, w_inv_hit;

    assign w_p_idx    = proc_addr[INDEX_W-1:0];
    assign w_p_tag    = proc_addr[ADDR_W-1:INDEX_W];
    assign w_wb_idx   = wb_add[INDEX_W-1:0];
    assign w_wb_tag   = wb_add[ADDR_W-1:INDEX_W];
    assign w_inv_idx  = blocknum[INDEX_W-1:0];
    assign w_inv_tag  = blocknum[ADDR_W-1:INDEX_W];
    assign w_fill_idx = r_blk_add[INDEX_W-1:0];
    assign w_fill_tag = r_blk_add[ADDR_W-1:INDEX_W];

    assign w_p_hit   = (r_lst[w_p_idx] != c_LS_INV) && (r_tag[w_p_idx] == w_p_tag);
    assign w_p_excl  = (r_lst[w_p_idx] == c_LS_EXC) && (r_tag[w_p_idx] == w_p_tag);
    assign w_wb_hit  = (r_lst[w_wb_idx] != c_LS_INV) && (r_tag[w_wb_idx] == w_wb_tag);
    assign w_inv_hit = (r_lst[w_inv_idx] != c_LS_INV) && (r_tag[w_inv_idx] == w_inv_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_saved_state <= S_IDLE;
            r_cache_req   <= c_REQ_IDLE;
            r_saved_req   <= c_REQ_IDLE;
            r_blk_add     <= '0;
            r_back_data   <= 1'b0;
            r_proc_rdata  <= 1'b0;
            r_lst         <= '0;
            r_tag         <= '0;
            r_data        <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_saved_state <= w_nxt_saved_state;
            r_cache_req   <= w_nxt_cache_req;
            r_saved_req   <= w_nxt_saved_req;
            r_blk_add     <= w_nxt_blk_add;
            r_back_data   <= w_nxt_back_data;
            r_proc_rdata  <= w_nxt_proc_rdata;
            r_lst         <= w_nxt_lst;
            r_tag         <= w_nxt_tag;
            r_data        <= w_nxt_data;
        end
    end

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_saved_state = r_saved_state;
        w_nxt_cache_req   = r_cache_req;
        w_nxt_saved_req   = r_saved_req;
        w_nxt_blk_add     = r_blk_add;
        w_nxt_back_data   = r_back_data;
        w_nxt_proc_rdata  = r_proc_rdata;
        w_nxt_lst         = r_lst;
        w_nxt_tag         = r_tag;
        w_nxt_data        = r_data;
        w_fill            = 1'b0;

        if (write_back_req && (r_state != S_WB_RESP)) begin
            // The ACK pulse is already out when a snoop lands on it, so resume in IDLE.
            w_nxt_saved_state = (r_state == S_ACK) ? S_IDLE : r_state;
            w_nxt_saved_req   = r_cache_req;
            w_nxt_cache_req   = c_REQ_OK;
            w_nxt_back_data   = w_wb_hit ? r_data[w_wb_idx] : 1'b0;
            if (w_wb_hit && (r_lst[w_wb_idx] == c_LS_EXC))
                w_nxt_lst[w_wb_idx] = c_LS_SHR;
            w_nxt_state = S_WB_RESP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (proc_req == c_PREQ_RD) begin
                        if (w_p_hit) begin
                            w_nxt_proc_rdata = r_data[w_p_idx];
                            w_nxt_state      = S_ACK;
                        end else begin
                            w_nxt_cache_req = c_REQ_RD;
                            w_nxt_blk_add   = proc_addr;
                            w_nxt_state     = S_RD_MISS;
                        end
                    end else if (proc_req == c_PREQ_WR) begin
                        if (w_p_excl) begin
                            w_nxt_data[w_p_idx] = proc_wdata;
                            w_nxt_state         = S_ACK;
                        end else begin
                            w_nxt_cache_req = c_REQ_EXCL;
                            w_nxt_blk_add   = proc_addr;
                            w_nxt_state     = S_WR_MISS;
                        end
                    end
                end
                S_RD_MISS: begin
                    if (blk_ok) begin
                        // A read fill costs this cache every write ownership it held.
                        for (int i = 0; i < c_NUM_LINES; i++) begin
                            if (r_lst[i] == c_LS_EXC)
                                w_nxt_lst[i] = c_LS_SHR;
                        end
                        w_fill                 = 1'b1;
                        w_nxt_lst[w_fill_idx]  = c_LS_SHR;
                        w_nxt_tag[w_fill_idx]  = w_fill_tag;
                        w_nxt_data[w_fill_idx] = blk_data;
                        w_nxt_proc_rdata       = blk_data;
                        w_nxt_cache_req        = c_REQ_IDLE;
                        w_nxt_state            = S_ACK;
                    end
                end
                S_WR_MISS: begin
                    if (blk_ok) begin
                        w_fill                 = 1'b1;
                        w_nxt_lst[w_fill_idx]  = c_LS_EXC;
                        w_nxt_tag[w_fill_idx]  = w_fill_tag;
                        w_nxt_data[w_fill_idx] = proc_wdata;
                        w_nxt_cache_req        = c_REQ_IDLE;
                        w_nxt_state            = S_ACK;
                    end
                end
                S_WB_RESP: begin
                    w_nxt_state     = r_saved_state;
                    w_nxt_cache_req = r_saved_req;
                end
                S_ACK:   w_nxt_state = S_IDLE;
                default: w_nxt_state = S_IDLE;
            endcase
        end

        if (inval && w_inv_hit && !(w_fill && (w_inv_idx == w_fill_idx)))
            w_nxt_lst[w_inv_idx] = c_LS_INV;
    end

    assign proc_ack   = (r_state == S_ACK);
    assign proc_rdata = r_proc_rdata;
    assign cache_req  = r_cache_req;
    assign blk_add    = r_blk_add;
    assign back_data  = r_back_data;

`ifdef COH_CACHE_STATS_EN
    logic [15:0] r_hit_cnt, r_miss_cnt;
    logic        w_hit_evt, w_miss_evt;

    assign w_hit_evt  = (r_state == S_IDLE) && (w_nxt_state == S_ACK);
    assign w_miss_evt = (r_state == S_IDLE) &&
                        ((w_nxt_state == S_RD_MISS) || (w_nxt_state == S_WR_MISS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_evt && (r_hit_cnt != 16'hFFFF))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss_evt && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/coh_cache_ctrl.md
Name: coh_cache_ctrl

Overview:
- Per-processor cache controller sitting directly upstream of the two-port coherence directory; one instance per cache port.
- Turns processor read/write requests into directory requests (block read, block exclusive).
- Answers directory write-back requests and invalidations.
- Holds a direct-mapped array of 1-bit data blocks with INVALID/SHARED/EXCLUSIVE line state.

Parameters:
ADDR_W, 4, block address width; matches directory address_size+1
INDEX_W, 2, cache index width; NUM_LINES = 2**INDEX_W; tag = addr[ADDR_W-1:INDEX_W]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
proc_req  in  2  00 none, 01 read, 10 write, 11 reserved (treated as none); held until proc_ack
proc_addr  in  ADDR_W  processor block address
proc_wdata  in  1  write data
proc_rdata  out  1  read data, valid with proc_ack
proc_ack  out  1  one-cycle completion pulse
cache_req  out  2  to directory: 00 idle, 01 blk_rreq, 10 blk_excl, 11 ok; registered
blk_add  out  ADDR_W  request address to directory; registered
back_data  out  1  write-back data to directory; registered
blk_ok  in  1  directory grant
blk_data  in  1  directory fill data, valid with blk_ok
write_back_req  in  1  directory asks for the block at wb_add
wb_add  in  ADDR_W  the peer cache's blk_add, wired at top level
inval  in  1  invalidate the block at blocknum
blocknum  in  ADDR_W  invalidation address

Behaviour:
Reset:
- All lines INVALID, state IDLE.
- cache_req=00, blk_add=0, back_data=0, proc_rdata=0, proc_ack=0.

FSM states: IDLE, RD_MISS, WR_MISS, WB_RESP, ACK.
- IDLE, read hit (tag match, SHARED or EXCLUSIVE): go to ACK; proc_rdata=line data, proc_ack=1 in the next cycle.
- IDLE, write hit on an EXCLUSIVE line: line data=proc_wdata, go to ACK.
- IDLE, read miss: register cache_req=01 and blk_add=proc_addr, go to RD_MISS.
- IDLE, write miss or write to a SHARED line: register cache_req=10 and blk_add=proc_addr, go to WR_MISS.
- RD_MISS, blk_ok sampled high:
  - Install tag and blk_data as SHARED; proc_rdata=blk_data.
  - Downgrade every other EXCLUSIVE line to SHARED, because the directory drops this cache's write ownership on a read fill.
  - cache_req=00, go to ACK.
- WR_MISS, blk_ok sampled high: install tag and proc_wdata as EXCLUSIVE, cache_req=00, go to ACK.
- ACK: proc_ack=1 for exactly one cycle, then IDLE. A new proc_req is not sampled in the ACK cycle.
- Misses overwrite the indexed victim line with no write-back; the directory already holds the ownership record.

Snoop handling (evaluated at every edge, all states):
- write_back_req high, and state not WB_RESP:
  - Save the current state and cache_req.
  - Register cache_req=11 and back_data=line data for wb_add (0 if wb_add misses).
  - Downgrade that line EXCLUSIVE->SHARED; go to WB_RESP.
- WB_RESP: lasts exactly one cycle, during which the directory samples ok. Then restore the saved state and cache_req, so a pending blk_rreq/blk_excl resumes unchanged.
- inval high: line whose tag matches blocknum becomes INVALID at that edge. No response.
- inval and a fill to the same index in the same edge: the fill wins. The directory never asserts both, but the priority is fixed.
- write_back_req in the same edge as a local hit: the snoop is taken first, and the hit re-evaluates after WB_RESP.

Timing and reset:
- No combinational path from any directory input to cache_req, blk_add or back_data; this avoids a loop through the directory's write_back_req term.
- Reset asserted mid-transaction: abort immediately, all lines INVALID, outputs at reset values. No proc_ack is issued for the aborted request.

Optional Feature:
- Macro COH_CACHE_STATS_EN.
- When defined:
  - Outputs hit_cnt[15:0] and miss_cnt[15:0], both saturating at 16'hFFFF and reset to 0.
  - hit_cnt increments on the IDLE->ACK hit transition.
  - miss_cnt increments on entry to RD_MISS or WR_MISS.
- When undefined: the ports and counters are absent; functional behaviour is identical.

Test Plan:
- Read miss: read addr 4'h5, directory returns blk_ok with blk_data=1 three cycles later -> cache_req=01 and blk_add=5 until grant; then proc_rdata=1, proc_ack pulse; re-read 5 gives proc_ack 1 cycle after request with cache_req=00.
- Write upgrade: line 5 SHARED, write 0 -> cache_req=10 and blk_add=5; after blk_ok the line is EXCLUSIVE; a later write 1 hits locally; a read returns 1.
- Write-back during pending miss: line 9 EXCLUSIVE data 1, cache waiting in RD_MISS for addr 2; pulse write_back_req with wb_add=9 -> cache_req=11 and back_data=1 for one cycle; line 9 becomes SHARED; cache_req returns to 01 with blk_add=2.
- Invalidate: line 5 SHARED, inval=1 with blocknum=5 -> next read of 5 issues blk_rreq; inval with blocknum=6 leaves line 5 intact.
- Read fill downgrade: lines 1 and 3 EXCLUSIVE, read miss on 4'h8 completes -> lines 1 and 3 SHARED; a write to 1 issues blk_excl.
- Reset mid-operation: rst_n low while in WR_MISS -> cache_req=00 immediately; no proc_ack; all reads miss afterwards. With COH_CACHE_STATS_EN, counters read 0.
